// File: rtl/draw_write_arbiter_pkg.sv
// Shared types and helpers for the frame_buffer write arbiter.
// The optional statistics feature is enabled with DRAW_ARB_STATS_EN.
package draw_pkg;

  function automatic int addr_width(input int pixels);
    return (pixels > 1) ? $clog2(pixels) : 1;
  endfunction

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
  } arb_state_e;

  localparam int CH_FILL   = 0;
  localparam int CH_LINE   = 1;
  localparam int CH_SYMBOL = 2;

endpackage

// File: rtl/draw_write_arbiter_if.sv
// Drawer-side write channels: packed valid/ready/address/data for all drawers.
// Drawers drive through the master modport; the arbiter uses the slave modport.
interface draw_write_arbiter_if #(
  parameter int CHANNELS    = 3,
  parameter int ADDR_WIDTH  = 19,
  parameter int PIXEL_WIDTH = 1
);
  logic [CHANNELS-1:0]             ch_valid;
  logic [CHANNELS-1:0]             ch_ready;
  logic [CHANNELS*ADDR_WIDTH-1:0]  ch_addr;
  logic [CHANNELS*PIXEL_WIDTH-1:0] ch_data;

  modport master (output ch_valid, output ch_addr, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_addr, input ch_data, output ch_ready);
endinterface

// File: rtl/draw_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one above last_grant
// and wraps, so the most recently served channel has the lowest priority.
module rr_arbiter #(
  parameter int CHANNELS = 3,
  parameter int IDX_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic [CHANNELS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx,
  output logic                grant_vld
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      automatic int c = (int'(last_grant) + k) % CHANNELS;
      if (!grant_vld && req[c]) begin
        grant[c]  = 1'b1;
        grant_idx = IDX_W'(c);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_write_arbiter.sv
// Round-robin arbiter for the frame_buffer write port with drain-then-swap
// sequencing. Define DRAW_ARB_STATS_EN to add per-frame write/drop counters.
module draw_write_arbiter
  import draw_pkg::*;
#(
  parameter int CHANNELS          = 3,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int PIXEL_WIDTH       = 1,
  localparam int PIXELS_COUNT     = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int ADDR_WIDTH       = addr_width(PIXELS_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  draw_write_arbiter_if.slave    drw,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic                   fb_write_enable,
  output logic [ADDR_WIDTH-1:0]  fb_write_addr,
  output logic [PIXEL_WIDTH-1:0] fb_write_data,
  output logic                   fb_swap,
  output logic                   busy
`ifdef DRAW_ARB_STATS_EN
  ,
  output logic [31:0]            frame_write_count,
  output logic [15:0]            frame_drop_count
`endif
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  // One extra bit so the limit is representable even for power-of-two sizes.
  localparam logic [ADDR_WIDTH:0] PIX_LIM = (ADDR_WIDTH + 1)'(PIXELS_COUNT);

  arb_state_e state, state_nxt;
  logic [IDX_W-1:0]       last_grant;
  logic [CHANNELS-1:0]    grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;
  logic                   grant_en;
  logic                   accept_p0;
  logic                   in_range_p0;
  logic [ADDR_WIDTH-1:0]  addr_p0;
  logic [PIXEL_WIDTH-1:0] data_p0;
  logic                   vld_p1;
  logic [ADDR_WIDTH-1:0]  addr_p1;
  logic [PIXEL_WIDTH-1:0] data_p1;

  rr_arbiter #(.CHANNELS(CHANNELS), .IDX_W(IDX_W)) u_rr (
    .req        (drw.ch_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    fb_swap   = 1'b0;
    unique case (state)
      RUN: begin
        if (swap_req) state_nxt = DRAIN;
        else          grant_en  = 1'b1;
      end
      DRAIN: state_nxt = SWAP;
      SWAP: begin
        fb_swap   = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign drw.ch_ready = grant_en ? grant : '0;
  assign accept_p0    = grant_en && grant_vld;
  assign swap_ack     = fb_swap;

  always_comb begin
    addr_p0 = '0;
    data_p0 = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        addr_p0 = drw.ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        data_p0 = drw.ch_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
      end
    end
  end

  assign in_range_p0 = ({1'b0, addr_p0} < PIX_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      last_grant <= IDX_W'(CHANNELS - 1);
      vld_p1     <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= accept_p0 && in_range_p0;
      if (accept_p0) last_grant <= grant_idx;
    end
  end

  // ---- p0 -> p1: output register (data unreset; masked by vld_p1) ----
  always_ff @(posedge clk) begin
    addr_p1 <= addr_p0;
    data_p1 <= data_p0;
  end

  assign fb_write_enable = vld_p1;
  assign fb_write_addr   = vld_p1 ? addr_p1 : '0;
  assign fb_write_data   = vld_p1 ? data_p1 : '0;
  assign busy            = (state != RUN) || vld_p1;

`ifdef DRAW_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic [31:0] write_cnt;
  logic [15:0] drop_cnt;

  // Counters run per frame; the SWAP cycle publishes and restarts them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_cnt         <= '0;
      drop_cnt          <= '0;
      frame_write_count <= '0;
      frame_drop_count  <= '0;
    end else if (state == SWAP) begin
      frame_write_count <= write_cnt;
      frame_drop_count  <= drop_cnt;
      write_cnt         <= '0;
      drop_cnt          <= '0;
    end else if (accept_p0) begin
      if (in_range_p0) write_cnt <= sat_inc32(write_cnt);
      else             drop_cnt  <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_draw_write_arbiter.sv
// Directed bench for draw_write_arbiter; stats checks compile in with DRAW_ARB_STATS_EN.
module tb_draw_write_arbiter;
  import draw_pkg::*;

  localparam int CH  = 3;
  localparam int HOR = 640;
  localparam int VER = 480;
  localparam int PW  = 1;
  localparam int PIX = HOR * VER;
  localparam int AW  = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          swap_req = 1'b0;
  logic          swap_ack;
  logic          fb_write_enable;
  logic [AW-1:0] fb_write_addr;
  logic [PW-1:0] fb_write_data;
  logic          fb_swap;
  logic          busy;
`ifdef DRAW_ARB_STATS_EN
  logic [31:0]   frame_write_count;
  logic [15:0]   frame_drop_count;
`endif

  int checks = 0;
  int failures = 0;

  draw_write_arbiter_if #(.CHANNELS(CH), .ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) drw ();

  draw_write_arbiter #(
    .CHANNELS(CH), .HOR_ACTIVE_PIXELS(HOR), .VER_ACTIVE_PIXELS(VER), .PIXEL_WIDTH(PW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .drw             (drw),
    .swap_req        (swap_req),
    .swap_ack        (swap_ack),
    .fb_write_enable (fb_write_enable),
    .fb_write_addr   (fb_write_addr),
    .fb_write_data   (fb_write_data),
    .fb_swap         (fb_swap),
    .busy            (busy)
`ifdef DRAW_ARB_STATS_EN
    ,
    .frame_write_count (frame_write_count),
    .frame_drop_count  (frame_drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input int addr, input int data);
    drw.ch_addr[ch*AW +: AW] = AW'(addr);
    drw.ch_data[ch*PW +: PW] = PW'(data);
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    step();
    step();
  endtask

  int order [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    drw.ch_valid = '0;
    drw.ch_addr  = '0;
    drw.ch_data  = '0;
    step();
    step();
    chk("rst_we",    fb_write_enable, 0);
    chk("rst_swap",  fb_swap, 0);
    chk("rst_ack",   swap_ack, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", drw.ch_ready, 0);
    rst_n = 1'b1;
    step();

    // single write on the line channel
    drw.ch_valid = 3'b010;
    set_ch(CH_LINE, 100, 1);
    #1;
    chk("t1_ready", drw.ch_ready, 3'b010);
    step();
    drw.ch_valid = '0;
    chk("t1_we",   fb_write_enable, 1);
    chk("t1_addr", fb_write_addr, 100);
    chk("t1_data", fb_write_data, 1);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_idle_we", fb_write_enable, 0);

    // fresh reset, then all channels valid: strict rotation from channel 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < CH; i++) set_ch(i, 10 + i, i & 1);
    drw.ch_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_ready%0d", k), drw.ch_ready, 32'(1) << order[k]);
      if (k > 0) begin
        chk($sformatf("rr_addr%0d", k), fb_write_addr, 10 + order[k-1]);
        chk($sformatf("rr_data%0d", k), fb_write_data, order[k-1] & 1);
      end
      step();
    end
    drw.ch_valid = '0;
    chk("rr_addr_last", fb_write_addr, 12);

    // swap while channel 1 streams; a held request during DRAIN must not re-queue
    drw.ch_valid = 3'b010;
    set_ch(CH_LINE, 200, 1);
    #1;
    chk("sw_ready_pre", drw.ch_ready, 3'b010);
    step();
    set_ch(CH_LINE, 201, 0);
    swap_req = 1'b1;
    #1;
    chk("sw_ready_t",  drw.ch_ready, 0);
    chk("sw_we_t",     fb_write_enable, 1);
    chk("sw_addr_t",   fb_write_addr, 200);
    chk("sw_swap_t",   fb_swap, 0);
    step();
    chk("sw_ready_t1", drw.ch_ready, 0);
    chk("sw_we_t1",    fb_write_enable, 0);
    chk("sw_swap_t1",  fb_swap, 0);
    chk("sw_busy_t1",  busy, 1);
    step();
    swap_req = 1'b0;
    #1;
    chk("sw_swap_t2",  fb_swap, 1);
    chk("sw_ack_t2",   swap_ack, 1);
    chk("sw_ready_t2", drw.ch_ready, 0);
    step();
    chk("sw_ready_t3", drw.ch_ready, 3'b010);
    chk("sw_swap_t3",  fb_swap, 0);
    chk("sw_ack_t3",   swap_ack, 0);
`ifdef DRAW_ARB_STATS_EN
    chk("st_wr_frame1", frame_write_count, 7);
    chk("st_dr_frame1", frame_drop_count, 0);
`endif
    step();
    drw.ch_valid = '0;
    chk("sw_we_t4",   fb_write_enable, 1);
    chk("sw_addr_t4", fb_write_addr, 201);
    chk("sw_data_t4", fb_write_data, 0);

    // out-of-range address: accepted but dropped
    drw.ch_valid = 3'b001;
    set_ch(CH_FILL, PIX, 1);
    #1;
    chk("oor_ready", drw.ch_ready, 3'b001);
    step();
    drw.ch_valid = '0;
    chk("oor_we",   fb_write_enable, 0);
    chk("oor_addr", fb_write_addr, 0);
    chk("oor_data", fb_write_data, 0);
    chk("oor_busy", busy, 0);
`ifdef DRAW_ARB_STATS_EN
    do_swap();
    chk("st_drop", frame_drop_count, 1);
    chk("st_wr_frame2", frame_write_count, 1);
`endif

    // reset while a write sits in the output register; pointer is at channel 0
    for (int i = 0; i < CH; i++) set_ch(i, 10 + i, 1);
    drw.ch_valid = 3'b111;
    #1;
    chk("mr_ready", drw.ch_ready, 3'b010);
    step();
    chk("mr_we_pend", fb_write_enable, 1);
    chk("mr_addr_pend", fb_write_addr, 11);
    rst_n = 1'b0;
    #1;
    chk("mr_we_rst",   fb_write_enable, 0);
    chk("mr_addr_rst", fb_write_addr, 0);
    step();
    chk("mr_we_hold", fb_write_enable, 0);
    chk("mr_swap_hold", fb_swap, 0);
    rst_n = 1'b1;
    #1;
    chk("mr_ready_post", drw.ch_ready, 3'b001);
    step();
    drw.ch_valid = '0;
    chk("mr_addr_post", fb_write_addr, 10);

`ifdef DRAW_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("st_rst_wr", frame_write_count, 0);
    set_ch(CH_SYMBOL, 5, 1);
    drw.ch_valid = 3'b100;
    for (int i = 0; i < 500; i++) step();
    drw.ch_valid = '0;
    do_swap();
    chk("st_wr_500", frame_write_count, 500);
    drw.ch_valid = 3'b100;
    for (int i = 0; i < 20; i++) step();
    drw.ch_valid = '0;
    do_swap();
    chk("st_wr_20", frame_write_count, 20);
    chk("st_dr_0",  frame_drop_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_write_arbiter.md
Name: draw_write_arbiter

Overview:
- Arbitrates the frame_buffer write port among N drawing engines, replacing the current OR-combined write buses, which require drawers to be mutually exclusive.
- Each drawer presents writes on a valid/ready channel; a round-robin grant forwards one write per cycle through a registered output stage.
- Also sequences buffer swaps: a swap request is held off until in-flight writes drain, then one swap pulse is issued to frame_buffer.

Parameters:
- CHANNELS, 3, number of drawer channels (>=1; index 0 = fill, 1 = line, 2 = symbol by convention).
- HOR_ACTIVE_PIXELS, 640, visible width in pixels.
- VER_ACTIVE_PIXELS, 480, visible height in pixels.
- PIXEL_WIDTH, 1, bits per pixel written.
- Derived localparams: PIXELS_COUNT = HOR*VER; ADDR_WIDTH = $clog2(PIXELS_COUNT).

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  asynchronous active-low reset.
- ch_valid  in  CHANNELS  per-channel write request.
- ch_ready  out  CHANNELS  per-channel accept; one-hot or zero.
- ch_addr  in  CHANNELS*ADDR_WIDTH  packed write addresses; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_data  in  CHANNELS*PIXEL_WIDTH  packed write data.
- swap_req  in  1  single-cycle request to swap buffers.
- swap_ack  out  1  single-cycle pulse, coincident with fb_swap.
- fb_write_enable  out  1  to frame_buffer.
- fb_write_addr  out  ADDR_WIDTH  to frame_buffer.
- fb_write_data  out  PIXEL_WIDTH  to frame_buffer.
- fb_swap  out  1  to frame_buffer swap.
- busy  out  1  high when not in RUN or the output register holds a write.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state RUN; round-robin pointer last_grant = CHANNELS-1, so channel 0 has first priority.
- Handshake: a transfer occurs on channel i when ch_valid[i] && ch_ready[i].
- ch_ready is combinational from ch_valid, state and pointer.
- ch_ready never depends on itself; a channel may hold valid indefinitely.
- Grant rule, in RUN: search from last_grant+1 upward, wrapping modulo CHANNELS; the first valid channel gets ready=1.
- last_grant updates to the granted index on transfer. No transfer leaves the pointer unchanged.
- Latency: an accepted write appears on fb_write_* exactly 1 cycle later, with fb_write_enable=1 for one cycle. Throughput is 1 write per cycle total.
- Range rule: if ch_addr >= PIXELS_COUNT, the write is still accepted (ready=1) but dropped; fb_write_enable stays 0 that cycle.
- When fb_write_enable=0, fb_write_addr and fb_write_data are 0.
- States:
  - RUN: normal granting. swap_req=1 -> DRAIN, and no grant is issued in that same cycle.
  - DRAIN: all ch_ready=0. The output register flushes any last write this cycle. -> SWAP next cycle.
  - SWAP: fb_swap=1 and swap_ack=1 for exactly this cycle; ch_ready=0. -> RUN.
- Swap sequence: swap_req at cycle t gives fb_swap at t+2. A write accepted at t-1 lands at t, before the swap.
- swap_req asserted in DRAIN or SWAP is ignored; no queuing.
- Reset asserted mid-operation: any pending output write is discarded; no fb_write_enable or fb_swap is emitted after rst_n falls.

Optional Feature:
- Macro DRAW_ARB_STATS_EN.
- Defined: adds output ports frame_write_count [31:0] and frame_drop_count [15:0].
  - Both counters are internal and saturate; they increment per forwarded or dropped write respectively.
  - Both are latched to their outputs and cleared in the SWAP cycle, so the outputs show the previous frame's totals.
  - Both outputs reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package draw_pkg: ADDR_WIDTH computation helper function, the arbiter state enum (RUN/DRAIN/SWAP), and channel index constants (CH_FILL=0, CH_LINE=1, CH_SYMBOL=2).
- One natural sub-module: rr_arbiter. It is combinational, parametrised by CHANNELS, takes the request vector and last_grant, and returns a one-hot grant and the grant index.
- The pointer register and FSM stay in draw_write_arbiter.

Test Plan:
- Reset, then ch_valid=3'b010 with addr 100, data 1 -> ch_ready=3'b010 the same cycle; next cycle fb_write_enable=1, fb_write_addr=100, fb_write_data=1.
- ch_valid=3'b111 held for 6 cycles after reset -> grant order 0,1,2,0,1,2; fb_write_addr follows with 1-cycle lag.
- Channel 1 streaming; swap_req pulse at cycle t -> ready=0 at t and t+1; fb_swap=swap_ack=1 only at t+2; the write accepted at t-1 appears at t; streaming resumes at t+3.
- ch_addr=307200 (=PIXELS_COUNT) with valid -> ready=1, fb_write_enable=0; with DRAW_ARB_STATS_EN defined, frame_drop_count=1 after the next swap.
- rst_n low for 1 cycle mid-stream (write pending in the output register) -> fb_write_enable=0 immediately; after release, channel 0 is granted first when all are valid.
- DRAW_ARB_STATS_EN defined: 500 writes, swap, 20 writes, swap -> frame_write_count reads 500 after the first swap and 20 after the second.
